// File: rtl/inv_ro_meas_ctrl.sv
// Ring-oscillator measurement controller.
// Enables an external inv-cell ring oscillator, selects its chain tap, waits a fixed settle
// interval, then counts rising edges of the divided oscillator output over a programmable
// gate window and reports the count with a one-cycle done pulse.
//
// Ports:
//   ck        clock, all state on rising edge
//   rst       synchronous active-high reset
//   start     request a measurement (accepted only when idle)
//   abort     cancel a measurement in progress; beats start when idle
//   tap_sel   chain tap, captured on accepted start
//   gate_len  gate window length in ck cycles, captured on accepted start
//   ro_in     divided oscillator output, asynchronous to ck
//   ro_en     oscillator enable
//   ro_tap    registered tap select to the oscillator mux
//   busy      high whenever not idle
//   done      single-cycle completion pulse
//   count     edge count of the last or current measurement
//   ovf       count saturated during the last measurement
module inv_ro_meas_ctrl #(
    parameter int unsigned TAP_W      = 3,
    parameter int unsigned GATE_W     = 16,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TAP_W-1:0]  tap_sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              ro_in,
    output logic              ro_en,
    output logic [TAP_W-1:0]  ro_tap,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYC);

    typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

    state_e             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [GATE_W-1:0]  gate_len_q, gate_len_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [SetW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               rise;

    // s1/s2 resynchronise ro_in; s3 is the history flop for edge detection.
    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        gate_len_d = gate_len_q;
        gate_d     = gate_q;
        settle_d   = settle_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    tap_d      = tap_sel;
                    gate_len_d = gate_len;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    settle_d   = SettleLoad;
                    state_d    = StSettle;
                end
            end
            StSettle: begin
                settle_d = settle_q - SetW'(1);
                if (abort) begin
                    state_d = StIdle;
                end else if (settle_q == SetW'(1)) begin
                    if (gate_len_q == '0) begin
                        state_d = StDone;
                    end else begin
                        gate_d  = gate_len_q;
                        state_d = StGate;
                    end
                end
            end
            StGate: begin
                // Saturate rather than wrap so a too-fast oscillator is visible via ovf.
                if (rise) begin
                    if (&count_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                gate_d = gate_q - GATE_W'(1);
                if (abort) begin
                    state_d = StIdle;
                end else if (gate_q == GATE_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= StIdle;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            tap_q      <= '0;
            gate_len_q <= '0;
            gate_q     <= '0;
            settle_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= ro_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            tap_q      <= tap_d;
            gate_len_q <= gate_len_d;
            gate_q     <= gate_d;
            settle_q   <= settle_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ro_en  = (state_q == StSettle) || (state_q == StGate);
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign ro_tap = tap_q;
    assign count  = count_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_inv_ro_meas_ctrl.sv
module tb_inv_ro_meas_ctrl;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  tap_sel = '0;
    logic [15:0] gate_len = '0;
    logic        ro_in = 1'b0;

    logic        ro_en_a, busy_a, done_a, ovf_a;
    logic [2:0]  ro_tap_a;
    logic [19:0] count_a;
    logic        ro_en_b, busy_b, done_b, ovf_b;
    logic [2:0]  ro_tap_b;
    logic [3:0]  count_b;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ro_half = 0;

    inv_ro_meas_ctrl dut_a (
        .ck(ck), .rst(rst), .start(start), .abort(abort), .tap_sel(tap_sel),
        .gate_len(gate_len), .ro_in(ro_in), .ro_en(ro_en_a), .ro_tap(ro_tap_a),
        .busy(busy_a), .done(done_a), .count(count_a), .ovf(ovf_a)
    );

    // Narrow-counter instance for saturation; shares all stimulus with dut_a.
    inv_ro_meas_ctrl #(.CNT_W(4)) dut_b (
        .ck(ck), .rst(rst), .start(start), .abort(abort), .tap_sel(tap_sel),
        .gate_len(gate_len), .ro_in(ro_in), .ro_en(ro_en_b), .ro_tap(ro_tap_b),
        .busy(busy_b), .done(done_b), .count(count_b), .ovf(ovf_b)
    );

    always #5 ck = ~ck;

    always @(negedge ck) if (done_a) done_cnt++;

    // Square wave of period 2*ro_half cycles; held low when ro_half is 0.
    initial begin
        forever begin
            if (ro_half == 0) begin
                @(negedge ck);
                ro_in = 1'b0;
            end else begin
                repeat (ro_half) @(negedge ck);
                ro_in = ~ro_in;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    // Returns in the first cycle after the accepting edge (t+1).
    task automatic do_start(input logic [2:0] tap, input logic [15:0] gl);
        @(negedge ck);
        start = 1'b1; tap_sel = tap; gate_len = gl;
        @(negedge ck);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ck);
            checks++;
            if ({ro_en_a, busy_a, done_a, ovf_a, ro_tap_a, count_a} !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: ro_en=%b busy=%b done=%b ovf=%b tap=%0d count=%0d, required all 0",
                         i, ro_en_a, busy_a, done_a, ovf_a, ro_tap_a, count_a);
            end
        end
    endtask

    task automatic test_basic;
        ro_half = 5;
        do_start(3'd5, 16'd100);
        checks++;
        if (busy_a !== 1'b1 || ro_en_a !== 1'b1 || ro_tap_a !== 3'd5 || count_a !== 20'd0) begin
            errors++;
            $display("FAIL basic_t1: busy=%b ro_en=%b tap=%0d count=%0d, required 1 1 5 0",
                     busy_a, ro_en_a, ro_tap_a, count_a);
        end
        wait_cyc(107);  // t+108, last GATE cycle
        checks++;
        if (done_a !== 1'b0 || ro_en_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_t108: done=%b ro_en=%b, required 0 1", done_a, ro_en_a);
        end
        wait_cyc(1);    // t+109, DONE
        checks++;
        if (done_a !== 1'b1 || ro_en_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: done=%b ro_en=%b busy=%b, required 1 0 1",
                     done_a, ro_en_a, busy_a);
        end
        checks++;
        if (count_a < 20'd9 || count_a > 20'd11 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: count=%0d ovf=%b, required 9..11 and 0", count_a, ovf_a);
        end
        wait_cyc(1);    // t+110, IDLE
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || ro_tap_a !== 3'd5) begin
            errors++;
            $display("FAIL basic_idle: busy=%b done=%b tap=%0d, required 0 0 5",
                     busy_a, done_a, ro_tap_a);
        end
        ro_half = 0;
        wait_cyc(10);
    endtask

    task automatic test_zero_gate;
        do_start(3'd3, 16'd0);   // t+1
        wait_cyc(1);             // t+2: pulse start with other fields during SETTLE
        start = 1'b1; tap_sel = 3'd7; gate_len = 16'd50;
        wait_cyc(1);             // t+3
        start = 1'b0;
        wait_cyc(6);             // t+9
        checks++;
        if (done_a !== 1'b1 || count_a !== 20'd0 || ro_tap_a !== 3'd3) begin
            errors++;
            $display("FAIL zero_gate_done: done=%b count=%0d tap=%0d, required 1 0 3",
                     done_a, count_a, ro_tap_a);
        end
        wait_cyc(2);             // t+11: start not queued
        checks++;
        if (busy_a !== 1'b0 || ro_en_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_gate_noqueue: busy=%b ro_en=%b, required 0 0", busy_a, ro_en_a);
        end
    endtask

    task automatic test_saturation;
        ro_half = 4;
        do_start(3'd1, 16'd200);
        wait_cyc(208);           // t+209, DONE
        checks++;
        if (done_b !== 1'b1 || count_b !== 4'd15 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_narrow: done=%b count=%0d ovf=%b, required 1 15 1",
                     done_b, count_b, ovf_b);
        end
        checks++;
        if (count_a < 20'd24 || count_a > 20'd26 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL sat_wide: count=%0d ovf=%b, required 24..26 and 0", count_a, ovf_a);
        end
        ro_half = 0;
        wait_cyc(20);
        checks++;
        if (count_b !== 4'd15 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: count=%0d ovf=%b, required 15 1", count_b, ovf_b);
        end
        do_start(3'd0, 16'd0);
        checks++;
        if (count_b !== 4'd0 || ovf_b !== 1'b0 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear: count=%0d ovf=%b busy=%b, required 0 0 1",
                     count_b, ovf_b, busy_b);
        end
        wait_cyc(12);
    endtask

    task automatic test_abort;
        int partial;
        int dc;
        ro_half = 5;
        do_start(3'd2, 16'd100); // t+1
        wait_cyc(49);            // t+50
        abort = 1'b1;
        dc = done_cnt;
        wait_cyc(1);             // t+51
        abort = 1'b0;
        partial = int'(count_a);
        checks++;
        if (busy_a !== 1'b0 || ro_en_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b ro_en=%b done=%b, required 0 0 0",
                     busy_a, ro_en_a, done_a);
        end
        checks++;
        if (partial < 3 || partial > 6) begin
            errors++;
            $display("FAIL abort_partial: count=%0d, required 3..6", partial);
        end
        wait_cyc(70);
        checks++;
        if (int'(count_a) !== partial || done_cnt !== dc) begin
            errors++;
            $display("FAIL abort_hold: count=%0d done_pulses=%0d, required %0d and %0d",
                     count_a, done_cnt, partial, dc);
        end
        ro_half = 0;
        @(negedge ck);
        start = 1'b1; abort = 1'b1; tap_sel = 3'd6; gate_len = 16'd5;
        @(negedge ck);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || ro_tap_a !== 3'd2 || int'(count_a) !== partial) begin
            errors++;
            $display("FAIL abort_beats_start: busy=%b tap=%0d count=%0d, required 0 2 %0d",
                     busy_a, ro_tap_a, count_a, partial);
        end
    endtask

    task automatic test_reset_mid;
        int dc;
        ro_half = 5;
        do_start(3'd4, 16'd100);
        wait_cyc(30);            // in GATE
        @(negedge ck);
        rst = 1'b1;
        dc = done_cnt;
        @(negedge ck);
        rst = 1'b0;
        checks++;
        if ({ro_en_a, busy_a, done_a, ovf_a, ro_tap_a, count_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid: ro_en=%b busy=%b done=%b ovf=%b tap=%0d count=%0d, required all 0",
                     ro_en_a, busy_a, done_a, ovf_a, ro_tap_a, count_a);
        end
        wait_cyc(120);
        checks++;
        if (done_cnt !== dc || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done_pulses=%0d busy=%b, required %0d and 0",
                     done_cnt, busy_a, dc);
        end
        ro_half = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_gate();
        test_saturation();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
